// File: rtl/seq_encoder_8to3.sv
// Sequential 8-to-3 encoder: accepts a multi-hot vector and emits one index per set bit.
// Optional build macro MSB_FIRST_EN reverses the scan order (highest set bit first).
module seq_encoder_8to3 #(
  parameter int WIDTH = 8,
  parameter int IDXW  = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] D,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [IDXW-1:0]  X,
  output logic             Last,
  output logic             None
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state, state_n;
  logic [WIDTH-1:0]  pending, pending_n;
  logic              zflag, zflag_n;
  logic [IDXW-1:0]   sel_idx;
  logic              one_hot;
  logic              last_beat;

  // Priority pick over the registered pending bits; the last match in the loop wins.
  always_comb begin
    sel_idx = '0;
`ifdef MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++) begin
      if (pending[i]) sel_idx = IDXW'(i);
    end
`else
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending[i]) sel_idx = IDXW'(i);
    end
`endif
  end

  assign one_hot   = (pending != '0) && ((pending & (pending - WIDTH'(1))) == '0);
  assign last_beat = one_hot | zflag;

  always_comb begin
    state_n   = state;
    pending_n = pending;
    zflag_n   = zflag;
    In_ready  = 1'b0;
    Out_valid = 1'b0;
    X         = '0;
    Last      = 1'b0;
    None      = 1'b0;
    case (state)
      IDLE: begin
        In_ready = 1'b1;
        if (In_valid) begin
          pending_n = D;
          zflag_n   = (D == '0);
          state_n   = SCAN;
        end
      end
      SCAN: begin
        Out_valid = 1'b1;
        X         = sel_idx;
        Last      = last_beat;
        None      = zflag;
        if (Out_ready) begin
          pending_n = pending & ~(WIDTH'(1) << sel_idx);
          if (last_beat) begin
            zflag_n = 1'b0;
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      zflag   <= 1'b0;
    end else begin
      state   <= state_n;
      pending <= pending_n;
      zflag   <= zflag_n;
    end
  end

endmodule

// File: tb/tb_seq_encoder_8to3.sv
// Directed self-checking bench for seq_encoder_8to3; honours MSB_FIRST_EN for expected order.
module tb_seq_encoder_8to3;

  logic       clk = 1'b0;
  logic       rst;
  logic       In_valid;
  logic       In_ready;
  logic [7:0] D;
  logic       Out_valid;
  logic       Out_ready;
  logic [2:0] X;
  logic       Last;
  logic       None;

  int pass_cnt  = 0;
  int total_cnt = 0;

  seq_encoder_8to3 #(.WIDTH(8), .IDXW(3)) dut (
    .clk(clk), .rst(rst), .In_valid(In_valid), .In_ready(In_ready), .D(D),
    .Out_valid(Out_valid), .Out_ready(Out_ready), .X(X), .Last(Last), .None(None)
  );

  always #5 clk = ~clk;

  // n-th beat index for an all-ones vector in the configured scan order
  function automatic logic [2:0] ff_order(input int n);
`ifdef MSB_FIRST_EN
    return 3'(7 - n);
`else
    return 3'(n);
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1; In_valid = 1'b1; D = 8'hFF; Out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total_cnt++;
      if (Out_valid !== 1'b0) $display("[TB] FAIL reset_out_valid got %b want 0", Out_valid);
      else pass_cnt++;
      total_cnt++;
      if (dut.pending !== 8'h00) $display("[TB] FAIL reset_pending got %h want 00", dut.pending);
      else pass_cnt++;
    end
    rst = 1'b0; In_valid = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({In_ready, Out_valid, X, Last, None} !== 7'b1_0_000_0_0)
      $display("[TB] FAIL post_reset_outputs got rdy=%b vld=%b x=%0d last=%b none=%b want 1 0 0 0 0",
               In_ready, Out_valid, X, Last, None);
    else pass_cnt++;
  endtask

  task automatic test_multi_hot();
    logic [2:0] exp_x [4];
`ifdef MSB_FIRST_EN
    exp_x = '{3'd7, 3'd5, 3'd2, 3'd1};
`else
    exp_x = '{3'd1, 3'd2, 3'd5, 3'd7};
`endif
    In_valid = 1'b1; D = 8'b1010_0110; Out_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      In_valid = 1'b0;
      total_cnt++;
      if ({Out_valid, In_ready, X, Last, None} !== {1'b1, 1'b0, exp_x[n], n == 3, 1'b0})
        $display("[TB] FAIL multi_hot_beat%0d got vld=%b rdy=%b x=%0d last=%b none=%b want 1 0 %0d %b 0",
                 n, Out_valid, In_ready, X, Last, None, exp_x[n], n == 3);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if ({In_ready, Out_valid} !== 2'b10)
      $display("[TB] FAIL multi_hot_idle got rdy=%b vld=%b want 1 0", In_ready, Out_valid);
    else pass_cnt++;
  endtask

  task automatic test_one_hot();
    logic [7:0] vec;
    logic [7:0] decoded;
    for (int k = 0; k < 8; k++) begin
      vec = 8'(1) << k;
      In_valid = 1'b1; D = vec; Out_ready = 1'b1;
      @(negedge clk);
      In_valid = 1'b0;
      total_cnt++;
      if ({Out_valid, X, Last, None} !== {1'b1, 3'(k), 1'b1, 1'b0})
        $display("[TB] FAIL one_hot_k%0d got vld=%b x=%0d last=%b none=%b want 1 %0d 1 0",
                 k, Out_valid, X, Last, None, k);
      else pass_cnt++;
      decoded = 8'(1) << X;
      total_cnt++;
      if (decoded !== vec) $display("[TB] FAIL round_trip_k%0d got %h want %h", k, decoded, vec);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({In_ready, Out_valid} !== 2'b10)
        $display("[TB] FAIL one_hot_idle_k%0d got rdy=%b vld=%b want 1 0", k, In_ready, Out_valid);
      else pass_cnt++;
    end
  endtask

  task automatic test_zero();
    In_valid = 1'b1; D = 8'h00; Out_ready = 1'b0;
    @(negedge clk);
    In_valid = 1'b0;
    total_cnt++;
    if ({Out_valid, X, Last, None} !== {1'b1, 3'd0, 1'b1, 1'b1})
      $display("[TB] FAIL zero_beat got vld=%b x=%0d last=%b none=%b want 1 0 1 1",
               Out_valid, X, Last, None);
    else pass_cnt++;
    Out_ready = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({In_ready, Out_valid} !== 2'b10)
      $display("[TB] FAIL zero_idle got rdy=%b vld=%b want 1 0", In_ready, Out_valid);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    int n   = 0;
    int cyc = 0;
    In_valid = 1'b1; D = 8'hFF; Out_ready = 1'b0;
    while (n < 8 && cyc < 60) begin
      @(negedge clk);
      if (cyc == 2) begin
        In_valid = 1'b1; D = 8'h01;
      end else begin
        In_valid = 1'b0;
      end
      total_cnt++;
      if ({Out_valid, In_ready, X, Last, None} !== {1'b1, 1'b0, ff_order(n), n == 7, 1'b0})
        $display("[TB] FAIL bp_beat%0d_cyc%0d got vld=%b rdy=%b x=%0d last=%b none=%b want 1 0 %0d %b 0",
                 n, cyc, Out_valid, In_ready, X, Last, None, ff_order(n), n == 7);
      else pass_cnt++;
      Out_ready = (cyc % 3 == 0);
      if (Out_ready) n++;
      cyc++;
    end
    total_cnt++;
    if (n != 8) $display("[TB] FAIL bp_beat_count got %0d want 8", n);
    else pass_cnt++;
    @(negedge clk);
    In_valid = 1'b0; Out_ready = 1'b1;
    total_cnt++;
    if ({In_ready, Out_valid} !== 2'b10)
      $display("[TB] FAIL bp_idle got rdy=%b vld=%b want 1 0", In_ready, Out_valid);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if (Out_valid !== 1'b0) $display("[TB] FAIL bp_ghost_beat got vld=%b want 0", Out_valid);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [2:0] first_x [2];
`ifdef MSB_FIRST_EN
    first_x = '{3'd1, 3'd0};
`else
    first_x = '{3'd0, 3'd1};
`endif
    In_valid = 1'b1; D = 8'h03; Out_ready = 1'b1;
    @(negedge clk);
    D = 8'h80;
    for (int n = 0; n < 2; n++) begin
      if (n == 1) @(negedge clk);
      total_cnt++;
      if ({Out_valid, X, Last} !== {1'b1, first_x[n], n == 1})
        $display("[TB] FAIL b2b_first_beat%0d got vld=%b x=%0d last=%b want 1 %0d %b",
                 n, Out_valid, X, Last, first_x[n], n == 1);
      else pass_cnt++;
    end
    @(negedge clk);
    total_cnt++;
    if ({In_ready, Out_valid} !== 2'b10)
      $display("[TB] FAIL b2b_bubble got rdy=%b vld=%b want 1 0", In_ready, Out_valid);
    else pass_cnt++;
    @(negedge clk);
    In_valid = 1'b0;
    total_cnt++;
    if ({Out_valid, X, Last, None} !== {1'b1, 3'd7, 1'b1, 1'b0})
      $display("[TB] FAIL b2b_second got vld=%b x=%0d last=%b none=%b want 1 7 1 0",
               Out_valid, X, Last, None);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++;
    if ({In_ready, Out_valid} !== 2'b10)
      $display("[TB] FAIL b2b_idle got rdy=%b vld=%b want 1 0", In_ready, Out_valid);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp_x [3];
`ifdef MSB_FIRST_EN
    exp_x = '{3'd7, 3'd6, 3'd5};
`else
    exp_x = '{3'd4, 3'd5, 3'd6};
`endif
    In_valid = 1'b1; D = 8'hF0; Out_ready = 1'b1;
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      In_valid = 1'b0;
      total_cnt++;
      if ({Out_valid, X, Last} !== {1'b1, exp_x[n], 1'b0})
        $display("[TB] FAIL rst_mid_beat%0d got vld=%b x=%0d last=%b want 1 %0d 0",
                 n, Out_valid, X, Last, exp_x[n]);
      else pass_cnt++;
    end
    rst = 1'b1; Out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0; Out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      total_cnt++;
      if ({In_ready, Out_valid, X, Last, None} !== 7'b1_0_000_0_0)
        $display("[TB] FAIL rst_mid_after%0d got rdy=%b vld=%b x=%0d last=%b none=%b want 1 0 0 0 0",
                 c, In_ready, Out_valid, X, Last, None);
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; In_valid = 1'b0; D = 8'h00; Out_ready = 1'b0;
    test_reset();
    test_multi_hot();
    test_one_hot();
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
